// File: rtl/reg_bank_write_arbiter.sv
// reg_bank_write_arbiter: round-robin write arbiter and soft-clear sequencer for a bank of
// NREG single-bit register cells. One requester wins per cycle and drives a one-hot reg_en
// plus reg_din into the bank. A clear request sweeps every cell to 0, one cell per cycle.
// Optional feature macro: REGARB_GRANT_CNT_EN adds the saturating grant_cnt output.
// All outputs are registered; there is no combinational path from inputs to outputs.

module reg_bank_write_arbiter #(
`ifdef REGARB_GRANT_CNT_EN
    parameter int unsigned CNT_W = 16,
`endif
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NREG  = 8,
    parameter int unsigned AW    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ-1:0]    req_din,
    input  logic               clear_req,
    output logic [NREQ-1:0]    gnt,
    output logic [NREG-1:0]    reg_en,
    output logic               reg_din,
    output logic               clear_busy,
`ifdef REGARB_GRANT_CNT_EN
    output logic [CNT_W-1:0]   grant_cnt,
`endif
    output logic               addr_err
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [0:0] {
        StArb,
        StClear
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREG-1:0] reg_en_q, reg_en_d;
    logic            reg_din_q, reg_din_d;
    logic            clear_busy_q, clear_busy_d;
    logic            addr_err_q, addr_err_d;

    logic [NREQ-1:0] eligible;
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] win_oh;
    logic [AW-1:0]   win_addr;
    logic            win_din;
    logic            win_addr_ok;
    logic [NREG-1:0] win_dec;
    logic [IW-1:0]   idx_inc;
    logic [NREG-1:0] sweep_next_oh;
    logic            issue_grant;

    // Round-robin pick: first eligible index at/after ptr, then wrap to the indices below ptr.
    always_comb begin
        eligible  = req & ~gnt_q;
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        win_addr  = '0;
        win_din   = 1'b0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!win_found && eligible[j] && (PW'(j) >= ptr_q)) begin
                win_found = 1'b1;
                win_idx   = PW'(j);
                win_oh[j] = 1'b1;
                win_addr  = req_addr[j*AW +: AW];
                win_din   = req_din[j];
            end
        end
        // Any eligible index left after the first pass necessarily lies below ptr.
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!win_found && eligible[j]) begin
                win_found = 1'b1;
                win_idx   = PW'(j);
                win_oh[j] = 1'b1;
                win_addr  = req_addr[j*AW +: AW];
                win_din   = req_din[j];
            end
        end
    end

    // Decode the winner's address and the next sweep position into one-hot bank enables.
    always_comb begin
        win_addr_ok   = (32'(win_addr) < NREG);
        idx_inc       = idx_q + 1'b1;
        win_dec       = '0;
        sweep_next_oh = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            win_dec[r]       = (32'(win_addr) == r);
            sweep_next_oh[r] = (idx_inc == IW'(r));
        end
    end

    // Next-state and registered-output logic for the ARB/CLEAR sequencer.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        gnt_d        = '0;
        reg_en_d     = '0;
        reg_din_d    = 1'b0;
        clear_busy_d = 1'b0;
        addr_err_d   = 1'b0;
        issue_grant  = 1'b0;

        unique case (state_q)
            StArb: begin
                if (clear_req) begin
                    // Clear beats any pending request; first swept cell shows next cycle.
                    state_d      = StClear;
                    idx_d        = '0;
                    reg_en_d     = {{(NREG-1){1'b0}}, 1'b1};
                    clear_busy_d = 1'b1;
                end else begin
                    issue_grant = 1'b1;
                end
            end
            StClear: begin
                if (idx_q == IW'(NREG - 1)) begin
                    // Last sweep cycle: this edge already arbitrates, clear_req ignored.
                    state_d     = StArb;
                    issue_grant = 1'b1;
                end else begin
                    idx_d        = idx_inc;
                    reg_en_d     = sweep_next_oh;
                    clear_busy_d = 1'b1;
                end
            end
            default: begin
                state_d = StArb;
            end
        endcase

        if (issue_grant && win_found) begin
            gnt_d     = win_oh;
            reg_din_d = win_din;
            if (win_addr_ok) begin
                reg_en_d = win_dec;
            end else begin
                addr_err_d = 1'b1;
            end
            ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // State and output registers; asynchronous active-low reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StArb;
            ptr_q        <= '0;
            idx_q        <= '0;
            gnt_q        <= '0;
            reg_en_q     <= '0;
            reg_din_q    <= 1'b0;
            clear_busy_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            gnt_q        <= gnt_d;
            reg_en_q     <= reg_en_d;
            reg_din_q    <= reg_din_d;
            clear_busy_q <= clear_busy_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign gnt        = gnt_q;
    assign reg_en     = reg_en_q;
    assign reg_din    = reg_din_q;
    assign clear_busy = clear_busy_q;
    assign addr_err   = addr_err_q;

`ifdef REGARB_GRANT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count every issued grant (including dropped out-of-range writes), saturating at max.
    always_comb begin
        cnt_d = cnt_q;
        if ((gnt_d != '0) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Grant counter register; only reset clears it, the sweep leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Scoreboard bench for reg_bank_write_arbiter: a stimulus process drives inputs on the falling
// edge and pushes the model's expected next-cycle outputs; a monitor pops and compares them
// shortly after each rising edge.

module tb_reg_bank_write_arbiter;

    localparam int NREQ  = 4;
    localparam int NREG  = 8;
    localparam int AW    = 4;
`ifdef REGARB_GRANT_CNT_EN
    localparam int CNT_W = 16;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_din;
    logic               clear_req;
    logic [NREQ-1:0]    gnt;
    logic [NREG-1:0]    reg_en;
    logic               reg_din;
    logic               clear_busy;
    logic               addr_err;
`ifdef REGARB_GRANT_CNT_EN
    logic [CNT_W-1:0]   grant_cnt;
`endif

    always #5 clk = ~clk;

    reg_bank_write_arbiter #(
        .NREQ (NREQ),
        .NREG (NREG),
        .AW   (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_addr   (req_addr),
        .req_din    (req_din),
        .clear_req  (clear_req),
        .gnt        (gnt),
        .reg_en     (reg_en),
        .reg_din    (reg_din),
        .clear_busy (clear_busy),
`ifdef REGARB_GRANT_CNT_EN
        .grant_cnt  (grant_cnt),
`endif
        .addr_err   (addr_err)
    );

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [NREG-1:0] reg_en;
        logic            reg_din;
        logic            clear_busy;
        logic            addr_err;
        int              cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state, in plain integers.
    int              m_ptr;
    int              m_last;   // requester granted in the current cycle, -1 if none
    int              m_sweep;  // cell being cleared in the current cycle, -1 if none
    int              m_cnt;
    logic [NREQ-1:0] m_gnt;

    function automatic void model_reset();
        m_ptr   = 0;
        m_last  = -1;
        m_sweep = -1;
        m_cnt   = 0;
        m_gnt   = '0;
    endfunction

    function automatic void set_addr(input int i, input int a);
        req_addr[i*AW +: AW] = AW'(a);
    endfunction

    // Apply current inputs for one clock: predict the next cycle's outputs, queue them, advance.
    task automatic tick();
        exp_t e;
        int   w;
        int   a;
        e.gnt        = '0;
        e.reg_en     = '0;
        e.reg_din    = 1'b0;
        e.clear_busy = 1'b0;
        e.addr_err   = 1'b0;
        w            = -1;
        if (m_sweep >= 0 && m_sweep < NREG - 1) begin
            m_sweep      = m_sweep + 1;
            e.reg_en     = NREG'(1) << m_sweep;
            e.clear_busy = 1'b1;
        end else if (m_sweep < 0 && clear_req) begin
            m_sweep      = 0;
            e.reg_en     = NREG'(1);
            e.clear_busy = 1'b1;
        end else begin
            m_sweep = -1;
            for (int i = 0; i < NREQ; i++) begin
                int j;
                j = (m_ptr + i) % NREQ;
                if (w < 0 && req[j] && j != m_last) w = j;
            end
            if (w >= 0) begin
                e.gnt     = NREQ'(1) << w;
                e.reg_din = req_din[w];
                a         = int'(req_addr[w*AW +: AW]);
                if (a < NREG) e.reg_en = NREG'(1) << a;
                else          e.addr_err = 1'b1;
                m_ptr = (w + 1) % NREQ;
`ifdef REGARB_GRANT_CNT_EN
                if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
`endif
            end
        end
        m_last = w;
        m_gnt  = e.gnt;
        e.cnt  = m_cnt;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Direct check that every output is zero (reset state).
    task automatic check_idle(input string name);
        logic bad;
        bad = (gnt != '0) || (reg_en != '0) || reg_din || clear_busy || addr_err;
`ifdef REGARB_GRANT_CNT_EN
        if (grant_cnt != '0) bad = 1'b1;
`endif
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b reg_en=%b reg_din=%b clear_busy=%b addr_err=%b, want all 0",
                     name, gnt, reg_en, reg_din, clear_busy, addr_err);
        end
    endtask

    // Monitor: compare the DUT against the oldest queued expectation just after each edge.
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            logic bad;
            mon_e = sb_q.pop_front();
            bad = (gnt !== mon_e.gnt) || (reg_en !== mon_e.reg_en) ||
                  (reg_din !== mon_e.reg_din) || (clear_busy !== mon_e.clear_busy) ||
                  (addr_err !== mon_e.addr_err);
`ifdef REGARB_GRANT_CNT_EN
            if (grant_cnt !== CNT_W'(mon_e.cnt)) bad = 1'b1;
`endif
            n_vec++;
            if (bad) begin
                n_bad++;
                $display("FAIL outputs @%0t: got gnt=%b reg_en=%b din=%b busy=%b err=%b, want gnt=%b reg_en=%b din=%b busy=%b err=%b",
                         $time, gnt, reg_en, reg_din, clear_busy, addr_err,
                         mon_e.gnt, mon_e.reg_en, mon_e.reg_din, mon_e.clear_busy,
                         mon_e.addr_err);
            end
        end
    end

    initial begin
        reset     = 1'b0;
        req       = '0;
        req_addr  = '0;
        req_din   = '0;
        clear_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_idle("reset");
        reset = 1'b1;

        // Single request to cell 5.
        req = 4'b0001;
        set_addr(0, 5);
        req_din = 4'b0001;
        tick();
        req = '0;
        tick();

        // All four requesting the same cell: strict rotation.
        for (int i = 0; i < NREQ; i++) set_addr(i, 2);
        req     = 4'b1111;
        req_din = 4'b1010;
        repeat (8) tick();
        req = '0;
        repeat (2) tick();

        // Two requesters held: alternate, never the same one twice in a row.
        req     = 4'b0101;
        req_din = 4'b0001;
        repeat (6) tick();
        req = '0;
        tick();

        // Clear and request on the same edge: full sweep, then the grant.
        clear_req = 1'b1;
        req       = 4'b0010;
        set_addr(1, 3);
        req_din   = 4'b0010;
        tick();
        clear_req = 1'b0;
        repeat (NREG) tick();
        req = '0;
        tick();

        // Out-of-range address: grant pulses, write dropped, addr_err.
        req = 4'b0010;
        set_addr(1, 9);
        tick();
        req = '0;
        repeat (2) tick();

        // Reset asserted while the sweep is on cell 3.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        check_idle("reset mid-sweep");
        @(negedge clk);
        model_reset();
        reset = 1'b1;
        tick();

        // Randomized traffic obeying the requester rules.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (m_gnt[i]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            set_addr(i, int'($urandom_range(0, 11)));
                            req_din[i] = 1'($urandom_range(0, 1));
                        end else begin
                            req[i] = 1'b0;
                        end
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    set_addr(i, int'($urandom_range(0, 11)));
                    req_din[i] = 1'($urandom_range(0, 1));
                end
            end
            clear_req = ($urandom_range(0, 24) == 0);
            tick();
        end
        req       = '0;
        clear_req = 1'b0;
        repeat (NREG + 2) tick();

        n_vec++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
